// File: rtl/spi_arbiter_pkg.sv
// Shared SPI request/response types and field positions used by the arbiter,
// spi_master and the slot pollers.
package spi_arbiter_pkg;

  localparam int unsigned SPI_REQ_BITS  = 35;
  localparam int unsigned SPI_RESP_BITS = 32;

  localparam int unsigned REQ_ISREAD = 34;
  localparam int unsigned REQ_ADDR2  = 33;
  localparam int unsigned REQ_DATA2  = 32;

  typedef struct packed {
    logic        isread;
    logic        addr2;
    logic        data2;
    logic [15:0] addr;
    logic [15:0] data;
  } spi_req_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] rdata;
  } spi_resp_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side and spi_master-side signals of the SPI arbiter.
// slave: the arbiter's view; master: the surrounding system's view.
interface spi_arbiter_if #(
  parameter int unsigned N = 3,
  parameter int unsigned D = 4
);
  import spi_arbiter_pkg::*;

  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_ready;
  logic [N*SPI_REQ_BITS-1:0] req_data;

  logic                      spi_req_valid;
  logic                      spi_req_ready;
  logic [SPI_REQ_BITS-1:0]   spi_req_data;

  logic                      spi_resp_valid;
  logic                      spi_resp_ready;
  logic [SPI_RESP_BITS-1:0]  spi_resp_data;

  logic [N-1:0]              resp_valid;
  logic [N-1:0]              resp_ready;
  logic [SPI_RESP_BITS-1:0]  resp_data;

  logic [$clog2(D):0]        reads_pending;
  logic                      orphan_err;

  modport slave (
    input  req_valid, req_data,
    output req_ready,
    output spi_req_valid, spi_req_data,
    input  spi_req_ready,
    input  spi_resp_valid, spi_resp_data,
    output spi_resp_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    output reads_pending, orphan_err
  );

  modport master (
    output req_valid, req_data,
    input  req_ready,
    input  spi_req_valid, spi_req_data,
    output spi_req_ready,
    output spi_resp_valid, spi_resp_data,
    input  spi_resp_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    input  reads_pending, orphan_err
  );

endinterface

// File: rtl/spi_arbiter_id_fifo.sv
// Synchronous FIFO of requester IDs for reads in flight. Supports push and pop
// in the same cycle; a push into a full FIFO is taken only alongside a pop.
module spi_arbiter_id_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic                  clk_serial,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [Width-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [Width-1:0]      head_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Qualify push/pop against occupancy and advance pointers.
  always_comb begin
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q < CntW'(Depth)) || pop_ok);
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_serial) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk_serial) begin
    if (push_ok && !reset) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master between N requesters. Grants load
// a single output slot; read IDs are queued so responses return to their issuer.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned D = 4
) (
  input  logic         clk_serial,
  input  logic         reset,
  spi_arbiter_if.slave bus
);

  localparam int unsigned IdW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(D) + 1;

  spi_req_t         req_vec [N];
  logic [N-1:0]     eligible;
  logic             grant_any;
  logic [IdW-1:0]   grant_idx;
  logic             loadable, accept, id_free;

  logic [IdW-1:0]   ptr_q, ptr_d;
  logic             slot_valid_q, slot_valid_d;
  spi_req_t         slot_data_q, slot_data_d;
  logic             orphan_q, orphan_d;

  logic             fifo_push, fifo_pop, fifo_empty;
  logic [IdW-1:0]   head_id;
  logic [CntW-1:0]  fifo_count;

  // Unpack requests; a read is only eligible if an ID slot is free this cycle.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      req_vec[i]  = spi_req_t'(bus.req_data[i*SPI_REQ_BITS +: SPI_REQ_BITS]);
      eligible[i] = bus.req_valid[i] && (!req_vec[i].isread || id_free);
    end
  end

  // Rotating-priority scan starting at ptr_q; first eligible requester wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_any && eligible[idx[IdW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[IdW-1:0];
      end
    end
  end

  assign loadable      = !slot_valid_q || bus.spi_req_ready;
  assign accept        = loadable && grant_any && !reset;
  assign fifo_push     = accept && req_vec[grant_idx].isread;
  assign bus.req_ready = accept ? (N'(1) << grant_idx) : '0;

  // Response steering follows the oldest outstanding read; with nothing
  // outstanding the response is swallowed so spi_master never stalls.
  assign fifo_pop           = !fifo_empty && bus.spi_resp_valid && bus.resp_ready[head_id];
  assign id_free            = (fifo_count < CntW'(D)) || fifo_pop;
  assign bus.spi_resp_ready = fifo_empty ? 1'b1 : bus.resp_ready[head_id];
  assign bus.resp_valid     = (!fifo_empty && bus.spi_resp_valid) ? (N'(1) << head_id) : '0;
  assign bus.resp_data      = bus.spi_resp_data;

  // Next-state for slot, RR pointer and sticky orphan flag.
  always_comb begin
    ptr_d        = ptr_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    orphan_d     = orphan_q;
    if (accept) begin
      slot_valid_d = 1'b1;
      slot_data_d  = req_vec[grant_idx];
      ptr_d        = (grant_idx == IdW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.spi_req_ready) begin
      slot_valid_d = 1'b0;
      slot_data_d  = '0;
    end
    if (fifo_empty && bus.spi_resp_valid) begin
      orphan_d = 1'b1;
    end
  end

  // Registered slot, pointer and error state.
  always_ff @(posedge clk_serial) begin
    if (reset) begin
      ptr_q        <= '0;
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      orphan_q     <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      orphan_q     <= orphan_d;
    end
  end

  assign bus.spi_req_valid = slot_valid_q;
  assign bus.spi_req_data  = slot_data_q;
  assign bus.reads_pending = fifo_count;
  assign bus.orphan_err    = orphan_q;

  spi_arbiter_id_fifo #(
    .Width (IdW),
    .Depth (D)
  ) u_id_fifo (
    .clk_serial  (clk_serial),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (grant_idx),
    .pop_i       (fifo_pop),
    .head_o      (head_id),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomized bench for spi_arbiter: a stimulus process drives requesters and a
// behavioural spi_master, predicts results and queues them; a monitor on the
// opposite clock edge compares DUT outputs against those predictions.
module tb_spi_arbiter;
  import spi_arbiter_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned D  = 4;
  localparam int          NI = N;
  localparam int          DI = D;

  logic clk_serial = 1'b0;
  logic reset;
  always #5 clk_serial = ~clk_serial;

  spi_arbiter_if #(.N(N), .D(D)) bus ();

  spi_arbiter #(.N(N), .D(D)) dut (
    .clk_serial (clk_serial),
    .reset      (reset),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int          dest;
    logic [31:0] data;
  } resp_exp_t;

  // Reference model: current state and state after the coming edge.
  bit          m_slot_valid, n_slot_valid;
  logic [34:0] m_slot_data, n_slot_data;
  int          m_ptr, n_ptr;
  bit          m_orphan, n_orphan;
  int          m_ids[$];
  bit          n_clear, n_pop;
  int          n_push;

  // Per-cycle expectations and scoreboards.
  logic [N-1:0] exp_req_ready, exp_resp_valid;
  bit           exp_spi_resp_ready;
  logic [34:0]  exp_req_q[$];
  resp_exp_t    exp_resp_q[$];
  bit           mon_en = 1'b0;

  // Stimulus-side state: held requests and the behavioural spi_master.
  bit          req_hold[N];
  logic [34:0] req_word[N];
  logic [15:0] spi_pend[$];
  bit          resp_hold;
  logic [31:0] resp_word;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic apply_next();
    if (n_clear) m_ids.delete();
    else begin
      if (n_pop) m_ids.delete(0);
      if (n_push >= 0) m_ids.push_back(n_push);
    end
    m_slot_valid = n_slot_valid;
    m_slot_data  = n_slot_data;
    m_ptr        = n_ptr;
    m_orphan     = n_orphan;
    n_clear      = 1'b0;
    n_pop        = 1'b0;
    n_push       = -1;
  endtask

  task automatic step(input int p_req, input int p_read, input int p_sready,
                      input int p_resp, input int p_rready, input bit orphan_ok);
    bit          pop, load, idfree;
    int          g;
    logic [34:0] w;
    logic [15:0] a;
    resp_exp_t   er;
    @(posedge clk_serial);
    #1;
    apply_next();
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (!req_hold[i] && pct(p_req)) begin
        w[31:0]  = $urandom();
        w[33:32] = 2'($urandom());
        w[34]    = pct(p_read);
        req_hold[i] = 1'b1;
        req_word[i] = w;
      end
      bus.req_valid[i]         = req_hold[i];
      bus.req_data[i*35 +: 35] = req_word[i];
      bus.resp_ready[i]        = pct(p_rready);
    end
    bus.spi_req_ready = pct(p_sready);
    if (!resp_hold) begin
      if (spi_pend.size() > 0 && pct(p_resp)) begin
        a         = spi_pend.pop_front();
        resp_hold = 1'b1;
        resp_word = {a, 16'($urandom())};
      end else if (orphan_ok && m_ids.size() == 0 && pct(10)) begin
        resp_hold = 1'b1;
        resp_word = $urandom();
      end
    end
    bus.spi_resp_valid = resp_hold;
    bus.spi_resp_data  = resp_word;

    // Predict this cycle from the rules: oldest read owns the response,
    // rotating priority from the pointer, reads need a free ID slot.
    pop = (m_ids.size() > 0) && resp_hold && bus.resp_ready[m_ids[0]];
    exp_spi_resp_ready = (m_ids.size() == 0) ? 1'b1 : bus.resp_ready[m_ids[0]];
    exp_resp_valid = '0;
    if (m_ids.size() > 0 && resp_hold) exp_resp_valid[m_ids[0]] = 1'b1;
    load   = !m_slot_valid || bus.spi_req_ready;
    idfree = (m_ids.size() < DI) || pop;
    g = -1;
    if (load) begin
      for (int k = 0; k < NI; k++) begin
        int i;
        i = (m_ptr + k) % NI;
        if (g < 0 && req_hold[i] && (!req_word[i][34] || idfree)) g = i;
      end
    end
    exp_req_ready = '0;
    n_slot_valid  = m_slot_valid;
    n_slot_data   = m_slot_data;
    n_ptr         = m_ptr;
    n_orphan      = m_orphan;
    if (m_slot_valid && bus.spi_req_ready && m_slot_data[34]) spi_pend.push_back(m_slot_data[31:16]);
    if (g >= 0) begin
      exp_req_ready[g] = 1'b1;
      exp_req_q.push_back(req_word[g]);
      n_slot_valid = 1'b1;
      n_slot_data  = req_word[g];
      n_ptr        = (g + 1) % NI;
      req_hold[g]  = 1'b0;
      if (req_word[g][34]) n_push = g;
    end else if (bus.spi_req_ready) begin
      n_slot_valid = 1'b0;
      n_slot_data  = '0;
    end
    if (pop) begin
      er.dest = m_ids[0];
      er.data = resp_word;
      exp_resp_q.push_back(er);
      n_pop = 1'b1;
    end
    if (resp_hold && m_ids.size() == 0) n_orphan = 1'b1;
    if (resp_hold && exp_spi_resp_ready) resp_hold = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_serial);
    #1;
    apply_next();
    reset              = 1'b1;
    bus.req_valid      = '0;
    bus.spi_req_ready  = 1'b0;
    bus.spi_resp_valid = 1'b0;
    bus.resp_ready     = '1;
    for (int i = 0; i < NI; i++) req_hold[i] = 1'b0;
    resp_hold = 1'b0;
    spi_pend.delete();
    exp_req_q.delete();
    exp_resp_q.delete();
    exp_req_ready      = '0;
    exp_resp_valid     = '0;
    exp_spi_resp_ready = 1'b1;
    n_clear      = 1'b1;
    n_slot_valid = 1'b0;
    n_slot_data  = '0;
    n_ptr        = 0;
    n_orphan     = 1'b0;
  endtask

  // Monitor: compare on the falling edge, pop scoreboards on handshakes.
  always @(negedge clk_serial) begin
    if (mon_en) begin
      logic [34:0]  ew;
      resp_exp_t    er;
      logic [N-1:0] oh;
      check("req_ready", bus.req_ready, exp_req_ready);
      check("spi_req_valid", bus.spi_req_valid, m_slot_valid);
      check("spi_req_data", bus.spi_req_data, m_slot_data);
      check("reads_pending", bus.reads_pending, m_ids.size());
      check("orphan_err", bus.orphan_err, m_orphan);
      check("spi_resp_ready", bus.spi_resp_ready, exp_spi_resp_ready);
      check("resp_valid", bus.resp_valid, exp_resp_valid);
      if (bus.spi_req_valid && bus.spi_req_ready) begin
        check("spi_req_expected", exp_req_q.size() != 0, 1);
        if (exp_req_q.size() != 0) begin
          ew = exp_req_q.pop_front();
          check("spi_req_order", bus.spi_req_data, ew);
        end
      end
      if ((bus.resp_valid & bus.resp_ready) != '0) begin
        check("resp_expected", exp_resp_q.size() != 0, 1);
        if (exp_resp_q.size() != 0) begin
          er = exp_resp_q.pop_front();
          oh = '0;
          oh[er.dest] = 1'b1;
          check("resp_dest", bus.resp_valid, oh);
          check("resp_data", bus.resp_data, er.data);
        end
      end
    end
  end

  initial begin
    reset              = 1'b1;
    bus.req_valid      = '0;
    bus.req_data       = '0;
    bus.spi_req_ready  = 1'b0;
    bus.spi_resp_valid = 1'b0;
    bus.spi_resp_data  = '0;
    bus.resp_ready     = '1;
    for (int i = 0; i < NI; i++) begin
      req_hold[i] = 1'b0;
      req_word[i] = '0;
    end
    resp_hold    = 1'b0;
    resp_word    = '0;
    m_slot_valid = 1'b0;
    m_slot_data  = '0;
    m_ptr        = 0;
    m_orphan     = 1'b0;
    n_slot_valid = 1'b0;
    n_slot_data  = '0;
    n_ptr        = 0;
    n_orphan     = 1'b0;
    n_clear      = 1'b0;
    n_pop        = 1'b0;
    n_push       = -1;
    exp_req_ready      = '0;
    exp_resp_valid     = '0;
    exp_spi_resp_ready = 1'b1;
    repeat (2) @(posedge clk_serial);
    #1;
    mon_en = 1'b1;

    // All writes, sink always ready: strict rotation one per cycle.
    repeat (20) step(100, 0, 100, 0, 100, 0);
    // Sink stalled: slot must hold, no grants.
    repeat (8) step(100, 30, 0, 0, 100, 0);
    // General random traffic.
    repeat (300) step(60, 50, 70, 40, 70, 0);
    // Read-heavy with slow responses: ID FIFO fills, writes bypass blocked reads.
    repeat (200) step(80, 80, 80, 15, 50, 0);
    // Sparse traffic with occasional responses nobody asked for.
    repeat (100) step(20, 30, 80, 60, 80, 1);
    // Reset while the slot is occupied and reads are outstanding.
    for (int c = 0; c < 200; c++) begin
      step(70, 70, 30, 10, 50, 0);
      if (n_slot_valid && m_ids.size() >= 2) break;
    end
    do_reset();
    repeat (200) step(60, 50, 70, 40, 70, 0);
    // Drain everything outstanding.
    repeat (40) step(0, 0, 100, 100, 100, 0);
    @(negedge clk_serial);
    #1;
    check("drain_req_sb_empty", exp_req_q.size(), 0);
    check("drain_resp_sb_empty", exp_resp_q.size(), 0);
    check("drain_reads_pending", bus.reads_pending, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
